// File: rtl/dmem_responder.sv
// Fixed-latency data memory for the MEM stage: one request at a time, one-cycle response strobe, stall to hazard logic.
// Optional macro DMEM_BYTE_EN_EN: stores honour req_be; otherwise every non-error store writes the full word.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_we;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [29:0]      w_word;
  logic             w_err;
  logic             w_commit;
  logic [31:0]      w_rdata;

  // Word offset from the base; underflow is caught by the explicit below-base compare.
  assign w_word = 30'((req_addr - BASE_ADDR) >> 2);
  assign w_err  = (req_addr[1:0] != 2'b00) ||
                  (req_addr < BASE_ADDR)   ||
                  (w_word >= 30'(DEPTH_WORDS));

`ifdef DMEM_BYTE_EN_EN
  logic [3:0] r_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_be <= '0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_be <= req_be;
    end
  end
`else
  logic w_unused_be;
  assign w_unused_be = ^req_be;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_err   <= w_err;
            r_idx   <= w_word[IDX_W-1:0];
            r_wdata <= req_wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Store lands on the RESP edge so an abandoned (reset) access never reaches the array.
  assign w_commit = (r_state == S_RESP) && r_we && !r_err;

  always_ff @(posedge clk) begin
    if (w_commit) begin
`ifdef DMEM_BYTE_EN_EN
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
`else
      r_mem[r_idx] <= r_wdata;
`endif
    end
  end

  assign w_rdata   = r_mem[r_idx];

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_rdata : 32'd0;
  assign stall     = ((r_state == S_IDLE) && req_valid) || (r_state == S_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 at LATENCY=2, instance 1 at LATENCY=1, both checked every cycle
// against a cycle-stamped transaction model plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd0;
`ifdef DMEM_BYTE_EN_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_we, req_ready, rsp_valid, rsp_err, stall;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]  req_be;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .stall(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .stall(stall[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  int          lat_of [2] = '{2, 1};
  logic [31:0] m_mem   [2][DEPTH];
  bit          m_known [2][DEPTH];
  bit          m_pend  [2];
  int          m_resp_at [2];
  bit          m_we [2], m_err [2], m_rd_known [2];
  int          m_idx [2];
  logic [31:0] m_wd [2], m_rd [2];
  logic [3:0]  m_be [2];
  int          cyc = 0;
  bit          e_v, e_st;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (!BYTE_EN || be[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i] = 1'b0;
        chk("rst_ready", 32'(req_ready[i]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
        chk("rst_rdata", rsp_rdata[i], 32'd0);
        chk("rst_err", 32'(rsp_err[i]), 32'd0);
        chk("rst_stall", 32'(stall[i]), 32'd0);
      end else begin
        e_v  = m_pend[i] && (cyc == m_resp_at[i]);
        e_st = (!m_pend[i] && req_valid[i]) || (m_pend[i] && cyc < m_resp_at[i]);
        chk("rsp_valid", 32'(rsp_valid[i]), 32'(e_v));
        chk("req_ready", 32'(req_ready[i]), 32'(!m_pend[i]));
        chk("stall", 32'(stall[i]), 32'(e_st));
        chk("rsp_err", 32'(rsp_err[i]), 32'(e_v && m_err[i]));
        if (!e_v || m_rd_known[i]) chk("rsp_rdata", rsp_rdata[i], e_v ? m_rd[i] : 32'd0);
        if (e_v) begin
          if (m_we[i] && !m_err[i]) begin
            m_mem[i][m_idx[i]]   = merge(m_mem[i][m_idx[i]], m_wd[i], m_be[i]);
            m_known[i][m_idx[i]] = m_known[i][m_idx[i]] || !BYTE_EN || (m_be[i] == 4'hF);
          end
          m_pend[i] = 1'b0;
        end else if (!m_pend[i] && req_valid[i]) begin
          m_pend[i]    = 1'b1;
          m_resp_at[i] = cyc + lat_of[i];
          m_we[i]      = req_we[i];
          m_err[i]     = addr_bad(req_addr[i]);
          m_wd[i]      = req_wdata[i];
          m_be[i]      = req_be[i];
          m_idx[i]     = m_err[i] ? 0 : int'((req_addr[i] - BASE) >> 2);
          m_rd[i]      = (!m_we[i] && !m_err[i]) ? m_mem[i][m_idx[i]] : 32'd0;
          m_rd_known[i] = m_we[i] || m_err[i] || m_known[i][m_idx[i]];
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er, output int l);
    bit acc;
    int n;
    acc = 1'b0; n = 0; rd = '0; er = 1'b0; l = 0;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = wd; req_be[i] = be;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = (req_ready[i] === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_be[i]    = 4'($urandom);
    if (!acc) begin
      fail("accept_timeout");
      return;
    end
    acc = 1'b0;
    while (!acc && l < 40) begin
      @(negedge clk);
      l++;
      if (rsp_valid[i] === 1'b1) begin
        acc = 1'b1;
        rd  = rsp_rdata[i];
        er  = rsp_err[i];
      end
    end
    if (!acc) fail("rsp_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v;
    logic        er;
    int          l, kind;
    logic [31:0] a;
    bit [5:0]    s_st, s_rdy, s_vld;
    logic [31:0] s_rd [6];

    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < DEPTH; k++) do_req(0, 1'b1, BASE + 32'(k * 4), $urandom, 4'hF, rd, er, l);

    // store then load at LATENCY=2
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, l);
    chk("t1_st_lat", 32'(l), 32'd2);
    chk("t1_st_rdata", rd, 32'd0);
    chk("t1_st_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, l);
    chk("t1_ld_lat", 32'(l), 32'd2);
    chk("t1_ld_rdata", rd, 32'hDEADBEEF);

    // error accesses
    do_req(0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, l);
    chk("t2_mis_err", 32'(er), 32'd1);
    chk("t2_mis_rdata", rd, 32'd0);
    chk("t2_mis_lat", 32'(l), 32'd2);
    do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, rd, er, l);
    chk("t2_oor_err", 32'(er), 32'd1);
    chk("t2_oor_rdata", rd, 32'd0);
    do_req(0, 1'b1, 32'h12, 32'h0, 4'hF, rd, er, l);
    chk("t2_mis_st_err", 32'(er), 32'd1);
    do_req(0, 1'b1, 32'h104, 32'h0, 4'hF, rd, er, l);
    chk("t2_oor_st_err", 32'(er), 32'd1);
    do_req(0, 1'b1, 32'hFC, 32'h600DF00D, 4'hF, rd, er, l);
    chk("t2_last_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'hFC, 32'h0, 4'hF, rd, er, l);
    chk("t2_last_rdata", rd, 32'h600DF00D);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, l);
    chk("t2_unchanged", rd, 32'hDEADBEEF);

    // req_valid held across a store and a load
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      s_st[c] = stall[0]; s_rdy[c] = req_ready[0]; s_vld[c] = rsp_valid[0]; s_rd[c] = rsp_rdata[0];
      @(posedge clk); #1;
      if (c == 0) begin req_we[0] = 1'b0; req_wdata[0] = 32'h0; end
      if (c == 3) req_valid[0] = 1'b0;
    end
    chk("t3_stall_seq", 32'(s_st), 32'(6'b011011));
    chk("t3_ready_seq", 32'(s_rdy), 32'(6'b001001));
    chk("t3_valid_seq", 32'(s_vld), 32'(6'b100100));
    chk("t3_st_rdata", s_rd[2], 32'd0);
    chk("t3_ld_rdata", s_rd[5], 32'hCAFEF00D);

    // byte enables
    do_req(0, 1'b1, 32'h40, 32'h11223344, 4'hF, rd, er, l);
    do_req(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, er, l);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, l);
    chk("t4_be_rdata", rd, BYTE_EN ? 32'h11BB33DD : 32'hAABBCCDD);
    do_req(0, 1'b1, 32'h44, 32'h55667788, 4'hF, rd, er, l);
    do_req(0, 1'b1, 32'h44, 32'h99999999, 4'b0000, rd, er, l);
    chk("t4_be0_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h44, 32'h0, 4'hF, rd, er, l);
    chk("t4_be0_rdata", rd, BYTE_EN ? 32'h55667788 : 32'h99999999);

    // reset during BUSY of a store
    do_req(0, 1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, l);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'hF;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("t5_rst_ready", 32'(req_ready[0]), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, l);
    chk("t5_old_data", rd, 32'h12345678);

    // LATENCY=1 sweep
    for (int k = 0; k < DEPTH; k++) begin
      v = $urandom;
      do_req(1, 1'b1, BASE + 32'(k * 4), v, 4'hF, rd, er, l);
      chk("t6_st_lat", 32'(l), 32'd1);
      do_req(1, 1'b0, BASE + 32'(k * 4), 32'h0, 4'hF, rd, er, l);
      chk("t6_ld_lat", 32'(l), 32'd1);
      chk("t6_ld_rdata", rd, v);
    end

    // random traffic on the LATENCY=2 instance
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
      else                a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
      do_req(0, 1'($urandom), a, $urandom, 4'($urandom), rd, er, l);
      chk("rnd_lat", 32'(l), 32'd2);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
